mem_port_arbiter: RTL

//  Shares one single-ported unified memory between the pipelined CPU's fetch stage (16-bit instr) and memory stage (8-bit data).

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module mem_port_arbiter #(
   parameter int ADDR_W         = 8,
   parameter int IDATA_W        = 16,
   parameter int DDATA_W        = 8,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               if_req,
   input  logic [ADDR_W-1:0]  if_addr,
   output logic [IDATA_W-1:0] if_rdata,
   output logic               if_ready,
   input  logic               dm_req,
   input  logic               dm_we,
   input  logic [ADDR_W-1:0]  dm_addr,
   input  logic [DDATA_W-1:0] dm_wdata,
   output logic [DDATA_W-1:0] dm_rdata,
   output logic               dm_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [IDATA_W-1:0] mem_wdata,
   input  logic [IDATA_W-1:0] mem_rdata,
   input  logic               mem_ack,
   output logic               stall_f,
   output logic               stall_m,
   output logic [15:0]        stat_fetch_stall,
   output logic [15:0]        stat_data_grant
);
   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

   localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

   state_t     state, state_nxt;
   logic [3:0] burst_cnt;
   logic       f_elig, d_elig, grant_d, grant_f, done;

   assign stall_f = if_req & ~if_ready;
   assign stall_m = dm_req & ~dm_ready;

   // A side whose ready is high this cycle just completed, so it is not eligible.
   always_comb begin
      state_nxt = state;
      grant_d   = 1'b0;
      grant_f   = 1'b0;
      done      = 1'b0;
      f_elig    = if_req & ~if_ready;
      d_elig    = dm_req & ~dm_ready;
      case (state)
         IDLE: begin
            if (d_elig && !(f_elig && burst_cnt == BURST_MAX)) begin
               grant_d   = 1'b1;
               state_nxt = DATA;
            end else if (f_elig) begin
               grant_f   = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH, DATA: begin
            if (mem_ack) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         burst_cnt <= '0;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= IDATA_W'(dm_wdata);
            burst_cnt <= f_elig ? burst_cnt + 4'd1 : 4'd0;
         end else if (grant_f) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            burst_cnt <= 4'd0;
         end
         if (done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == FETCH) begin
               if_ready <= 1'b1;
               if_rdata <= mem_rdata;
            end else begin
               dm_ready <= 1'b1;
               if (!mem_we) dm_rdata <= mem_rdata[DDATA_W-1:0];
            end
         end
      end
   end

`ifdef ARB_STATS_EN
   // Saturating counters, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_fetch_stall <= '0;
         stat_data_grant  <= '0;
      end else begin
         if (stall_f && stat_fetch_stall != 16'hFFFF) stat_fetch_stall <= stat_fetch_stall + 16'd1;
         if (grant_d && stat_data_grant != 16'hFFFF)  stat_data_grant  <= stat_data_grant + 16'd1;
      end
   end
`else
   assign stat_fetch_stall = 16'h0000;
   assign stat_data_grant  = 16'h0000;
`endif

endmodule
